// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: geometry, scheduler state
// and the write-request bundle used by writeback stages.
package regfile_pkg;

    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned NUM_REGS     = 64;
    localparam int unsigned STARVE_LIMIT = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wr_arbiter_2to1.sv
// Fixed-priority 2:1 grant for the register-file write port, with a starvation
// counter that force-grants port B after STARVE_LIMIT consecutive refusals.
module wr_arbiter_2to1
    import regfile_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = regfile_pkg::STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic init_start,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_ready,
    output logic b_ready
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    logic [CntW-1:0] starveCnt;
    logic            forceB;

    always_comb begin
        forceB  = run && b_valid && (starveCnt == CntMax);
        a_ready = run && !forceB && !init_start;
        b_ready = run && !init_start && (forceB || !a_valid);
    end

    // Counts only arbitration losses in RUN; a sweep or an idle B restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (!run || init_start || !b_valid || b_ready) begin
            starveCnt <= '0;
        end else if (starveCnt != CntMax) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Sole driver of the register-file write port: zero-clear sweep after reset or on
// command, then arbitrated writeback (A) and load-return (B) traffic.
module regfile_write_scheduler #(
    parameter int unsigned NUM_REGS     = regfile_pkg::NUM_REGS,
    parameter int unsigned ADDR_W       = regfile_pkg::ADDR_W,
    parameter int unsigned DATA_W       = regfile_pkg::DATA_W,
    parameter int unsigned STARVE_LIMIT = regfile_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    output logic              init_busy,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

    state_e            state;
    logic [ADDR_W-1:0] sweepAddr;
    logic              run;
    wr_req_t           grant;

    assign run       = (state == RUN);
    assign init_busy = (state == INIT);

    wr_arbiter_2to1 #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) uArb (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .init_start(init_start),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .a_ready   (a_ready),
        .b_ready   (b_ready)
    );

    always_comb begin
        grant = '0;
        if (a_valid && a_ready) begin
            grant.valid = 1'b1;
            grant.addr  = a_addr;
            grant.data  = a_data;
        end else if (b_valid && b_ready) begin
            grant.valid = 1'b1;
            grant.addr  = b_addr;
            grant.data  = b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            sweepAddr <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    rf_we     <= 1'b1;
                    rf_waddr  <= sweepAddr;
                    rf_wdata  <= '0;
                    sweepAddr <= sweepAddr + 1'b1;
                    if (sweepAddr == LastAddr) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (init_start) begin
                        state     <= INIT;
                        sweepAddr <= '0;
                        rf_we     <= 1'b0;
                    end else begin
                        // Address and data hold when idle so the port only toggles on writes.
                        rf_we <= grant.valid;
                        if (grant.valid) begin
                            rf_waddr <= grant.addr;
                            rf_wdata <= grant.data;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench: per-cycle behavioural model plus directed literal checks.
module tb_regfile_write_scheduler;

    localparam int NREG = 64;
    localparam int LIM  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_start = 1'b0;
    logic        init_busy;
    logic        a_valid = 1'b0;
    logic [5:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [5:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;

    regfile_write_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .init_start(init_start),
        .init_busy (init_busy),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: sweep countdown, starvation count, expected port outputs.
    bit          mInit   = 1'b1;
    int          mSweep  = 0;
    int          mStarve = 0;
    bit          expWe   = 1'b0;
    bit          expBusy = 1'b1;
    logic [5:0]  expAddr = '0;
    logic [31:0] expData = '0;
    bit          mAr, mBr, mForce;
    logic [31:0] modelRf [NREG];
    logic [31:0] dutRf   [NREG];

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            mInit = 1'b1; mSweep = 0; mStarve = 0;
            expWe = 1'b0; expAddr = '0; expData = '0; expBusy = 1'b1;
        end else begin
            chk("rf_we", {31'd0, rf_we}, {31'd0, expWe});
            chk("rf_waddr", {26'd0, rf_waddr}, {26'd0, expAddr});
            chk("rf_wdata", rf_wdata, expData);
            chk("init_busy", {31'd0, init_busy}, {31'd0, expBusy});
            if (rf_we) dutRf[rf_waddr] = rf_wdata;
            if (mInit) begin
                mAr = 1'b0; mBr = 1'b0;
            end else begin
                mForce = (mStarve == LIM) && b_valid;
                mAr    = !mForce && !init_start;
                mBr    = !init_start && (mForce || !a_valid);
            end
            chk("a_ready", {31'd0, a_ready}, {31'd0, mAr});
            chk("b_ready", {31'd0, b_ready}, {31'd0, mBr});
            if (mInit) begin
                expWe = 1'b1; expAddr = mSweep[5:0]; expData = '0;
                modelRf[mSweep] = '0;
                mSweep++;
                if (mSweep == NREG) begin mInit = 1'b0; expBusy = 1'b0; end
            end else if (init_start) begin
                mInit = 1'b1; mSweep = 0; mStarve = 0; expWe = 1'b0; expBusy = 1'b1;
            end else begin
                if (a_valid && mAr) begin
                    expWe = 1'b1; expAddr = a_addr; expData = a_data;
                end else if (b_valid && mBr) begin
                    expWe = 1'b1; expAddr = b_addr; expData = b_data;
                end else begin
                    expWe = 1'b0;
                end
                if (expWe) modelRf[expAddr] = expData;
                if (b_valid && !mBr) mStarve = (mStarve < LIM) ? mStarve + 1 : LIM;
                else mStarve = 0;
            end
        end
    end

    task automatic sweep_literal();
        for (int i = 0; i < NREG; i++) begin
            @(posedge clk); #1;
            chk("sweep_we", {31'd0, rf_we}, 32'd1);
            chk("sweep_addr", {26'd0, rf_waddr}, i);
            chk("sweep_data", rf_wdata, 32'd0);
        end
        chk("busy_after_sweep", {31'd0, init_busy}, 32'd0);
    endtask

    int  firstB;
    int  n;
    bit  gotB;
    bit  aAcc, bAcc;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sweep_literal();
        chk("a_ready_after_sweep", {31'd0, a_ready}, 32'd1);

        // Single writeback, one-cycle latency.
        a_valid = 1'b1; a_addr = 6'd5; a_data = 32'hDEADBEEF;
        #2 chk("a_ready_same_cycle", {31'd0, a_ready}, 32'd1);
        @(posedge clk); #1 a_valid = 1'b0;
        chk("wb_we", {31'd0, rf_we}, 32'd1);
        chk("wb_addr", {26'd0, rf_waddr}, 32'd5);
        chk("wb_data", rf_wdata, 32'hDEADBEEF);

        // A and B to the same register: B lands last.
        a_valid = 1'b1; a_addr = 6'd7; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 6'd7; b_data = 32'h22;
        @(posedge clk); #1 a_valid = 1'b0;
        chk("same_addr_first", rf_wdata, 32'h11);
        @(posedge clk); #1 b_valid = 1'b0;
        chk("same_addr_second", rf_wdata, 32'h22);
        @(negedge clk); #1;
        chk("reg7_final", dutRf[7], 32'h22);
        @(posedge clk); #1;

        // Starvation guard, twice in a row to show the count restarts after a grant.
        for (int r = 0; r < 2; r++) begin
            b_valid = 1'b1; b_addr = 6'd9; b_data = 32'h55 + r;
            a_valid = 1'b1; a_addr = 6'd1;
            firstB = 0;
            for (int c = 1; c <= 8 && firstB == 0; c++) begin
                a_data = c;
                #2 gotB = b_ready;
                if (gotB) begin
                    firstB = c;
                    chk("a_ready_when_forced", {31'd0, a_ready}, 32'd0);
                end
                @(posedge clk); #1;
                if (gotB) b_valid = 1'b0;
            end
            chk("starve_grant_cycle", firstB, 32'd5);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;

        // init_start while A is pending.
        a_valid = 1'b1; a_addr = 6'd3; a_data = 32'h33; init_start = 1'b1;
        #2 chk("a_ready_init_start", {31'd0, a_ready}, 32'd0);
        @(posedge clk); #1 init_start = 1'b0;
        chk("busy_after_init_start", {31'd0, init_busy}, 32'd1);
        n = 0;
        while (n < 100) begin
            #2 if (a_ready) break;
            @(posedge clk); #1;
            n++;
        end
        chk("sweep_cycles_before_accept", n, 32'd64);
        @(posedge clk); #1 a_valid = 1'b0;

        // Async reset mid-sweep at address 30.
        init_start = 1'b1;
        @(posedge clk); #1 init_start = 1'b0;
        n = 0;
        while (n < 100 && !(rf_we && rf_waddr == 6'd30)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_addr30", {31'd0, (n < 100)}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_addr", {26'd0, rf_waddr}, 32'd0);
        chk("rst_busy", {31'd0, init_busy}, 32'd1);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        sweep_literal();

        // Randomized traffic with hold-until-accepted requesters.
        aAcc = 1'b0; bAcc = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (aAcc) a_valid = 1'b0;
            if (bAcc) b_valid = 1'b0;
            if (!a_valid && ($urandom % 3 != 0)) begin
                a_valid = 1'b1; a_addr = 6'($urandom); a_data = $urandom;
            end
            if (!b_valid && ($urandom % 2 == 0)) begin
                b_valid = 1'b1; b_addr = 6'($urandom); b_data = $urandom;
            end
            init_start = ($urandom % 250 == 0);
            #2;
            aAcc = a_valid && a_ready;
            bAcc = b_valid && b_ready;
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_valid = 1'b0; init_start = 1'b0;
        repeat (70) @(posedge clk);
        @(negedge clk); #1;
        for (int i = 0; i < NREG; i++) chk("final_reg", dutRf[i], modelRf[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 64x32 register file and is its only driver.
- Shares the port between two requesters: pipeline writeback (port A) and load/memory return (port B).
- Port A has fixed priority over port B. A starvation guard ensures port B is eventually served.
- Also sequences a zero-clear sweep of every register after reset or on command, before normal traffic is admitted.

Parameters:
- NUM_REGS, 64, number of registers swept during init; the sweep address counter spans 0..NUM_REGS-1.
- ADDR_W, 6, register address width.
- DATA_W, 32, register data width.
- STARVE_LIMIT, 4, consecutive cycles port B may be refused before it is force-granted.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_start  in  1  request a new clear sweep; honoured only in RUN.
- init_busy  out  1  high while the sweep is in progress.
- a_valid  in  1  writeback request valid.
- a_addr  in  ADDR_W  writeback destination register.
- a_data  in  DATA_W  writeback data.
- a_ready  out  1  writeback accepted this cycle (combinational).
- b_valid  in  1  load-return request valid.
- b_addr  in  ADDR_W  load-return destination register.
- b_data  in  DATA_W  load-return data.
- b_ready  out  1  load return accepted this cycle (combinational).
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_W  register-file write address (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).

Behaviour:
- Reset (async, any time, including mid-sweep or mid-transfer):
  - state=INIT, sweep_addr=0, starve_cnt=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, init_busy=1.
  - Any in-flight request is dropped; requesters must re-present it.
- INIT:
  - a_ready=b_ready=0.
  - Each cycle the registered outputs take rf_we=1, rf_waddr=sweep_addr, rf_wdata=0; sweep_addr then increments.
  - After the cycle that writes NUM_REGS-1, next state=RUN and init_busy falls.
  - The first rf_we pulse appears on the first edge after reset release.
  - Sweep duration is exactly NUM_REGS cycles.
  - init_start is ignored in this state.
- RUN, grant rules:
  - force_b = (starve_cnt == STARVE_LIMIT) && b_valid.
  - a_ready = !force_b && !init_start.
  - b_ready = !init_start && (force_b || !a_valid).
- RUN, transfers:
  - A transfer occurs when valid&ready on a port; at most one per cycle.
  - Latency is 1 cycle: the next edge registers rf_we=1, rf_waddr/rf_wdata from the granted port.
  - With no transfer, the registered rf_we=0; rf_waddr/rf_wdata hold their previous values.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when b_valid && !b_ready.
  - Clears on any B transfer, or when b_valid=0.
- init_start in RUN:
  - Both readies are 0 that cycle.
  - Next state=INIT, sweep_addr=0, starve_cnt=0, init_busy=1 on the next edge.
- Simultaneous A and B to the same address: A is written first; B is written in a later cycle, so B's data is the final value.
- Address 0 is an ordinary writable register (no hardwired zero).
- A requester holds valid/addr/data stable until accepted. The block does not buffer; a refused request simply waits.

Decomposition:
- Shared package regfile_pkg holds:
  - ADDR_W=6, DATA_W=32, NUM_REGS=64.
  - State enumeration INIT=1'b0, RUN=1'b1.
  - The write-request bundle typedef {valid, addr, data}, reused by the pipeline writeback stage.
- Natural sub-module: wr_arbiter_2to1, containing the combinational grant logic plus starve_cnt. The FSM, sweep counter and output registers stay in the top level.

Test Plan:
- Reset, then idle: rf_we high for cycles 1..64 with rf_waddr 0..63 and rf_wdata=0; init_busy falls after the address-63 write; a_ready=1 afterwards.
- In RUN, a_valid with a_addr=5, a_data=0xDEADBEEF: a_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Both valid, A addr 7 data 0x11, B addr 7 data 0x22: cycle 1 writes 0x11; B is written 0x22 once A drops valid; final reg7=0x22.
- A valid every cycle with B valid: B refused 4 cycles, then force-granted on cycle 5 (a_ready=0 that cycle); starve_cnt returns to 0.
- init_start asserted in RUN while A valid: a_ready=0; next edge init_busy=1 and the sweep restarts at address 0; A is accepted after 64 sweep cycles.
- Async rst pulsed mid-sweep at address 30: outputs zero immediately; after release the sweep restarts at address 0 and completes all 64 writes.
